// File: rtl/accel_avg_filter.sv
// Per-axis moving-average filter for 10-bit accelerometer samples.
// Keeps a 2^LOG2_DEPTH window and emits floor-averaged X/Y/Z two cycles after each accepted sample.
module accel_avg_filter #(
    parameter int LOG2_DEPTH = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic [9:0] i_data_x,
    input  logic [9:0] i_data_y,
    input  logic [9:0] i_data_z,
    input  logic       i_data_valid,
    output logic [9:0] o_avg_x,
    output logic [9:0] o_avg_y,
    output logic [9:0] o_avg_z,
    output logic       o_avg_valid,
    output logic       o_filled
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = 10 + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FILL_MAX = {1'b1, {LOG2_DEPTH{1'b0}}};

    logic        [9:0]          hist_q [3][DEPTH];
    logic signed [SW-1:0]       sum_q [3];
    logic signed [SW-1:0]       sum_d [3];
    logic        [9:0]          sample [3];
    logic        [9:0]          oldest [3];
    logic        [9:0]          shifted [3];
    logic        [LOG2_DEPTH-1:0] wrPtr_q;
    logic        [LOG2_DEPTH:0] fill_q;
    logic                       accepted_q;
    logic        [9:0]          avgStage_q [3];
    logic                       stageValid_q;
    logic        [9:0]          avg_q [3];
    logic                       avgValid_q;
    logic                       filled_q;
    logic                       full;

    function automatic logic signed [SW-1:0] sext(input logic [9:0] v);
        return $signed({{LOG2_DEPTH{v[9]}}, v});
    endfunction

    assign full = (fill_q == FILL_MAX);

    // Running sum swaps the oldest history entry for the new sample; the shift floors toward -inf.
    always_comb begin
        sample[0] = i_data_x;
        sample[1] = i_data_y;
        sample[2] = i_data_z;
        for (int a = 0; a < 3; a++) begin
            oldest[a]  = hist_q[a][wrPtr_q];
            sum_d[a]   = sum_q[a] + sext(sample[a]) - sext(oldest[a]);
            shifted[a] = 10'(sum_q[a] >>> LOG2_DEPTH);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int a = 0; a < 3; a++) begin
                for (int i = 0; i < DEPTH; i++) hist_q[a][i] <= '0;
                sum_q[a]      <= '0;
                avgStage_q[a] <= '0;
                avg_q[a]      <= '0;
            end
            wrPtr_q      <= '0;
            fill_q       <= '0;
            accepted_q   <= 1'b0;
            stageValid_q <= 1'b0;
            avgValid_q   <= 1'b0;
            filled_q     <= 1'b0;
        end else if (i_clear) begin
            // Clear takes priority over a coincident sample and kills any pulse in flight.
            for (int a = 0; a < 3; a++) begin
                for (int i = 0; i < DEPTH; i++) hist_q[a][i] <= '0;
                sum_q[a]      <= '0;
                avgStage_q[a] <= '0;
                avg_q[a]      <= '0;
            end
            wrPtr_q      <= '0;
            fill_q       <= '0;
            accepted_q   <= 1'b0;
            stageValid_q <= 1'b0;
            avgValid_q   <= 1'b0;
            filled_q     <= 1'b0;
        end else begin
            if (i_data_valid) begin
                for (int a = 0; a < 3; a++) begin
                    hist_q[a][wrPtr_q] <= sample[a];
                    sum_q[a]           <= sum_d[a];
                end
                wrPtr_q <= wrPtr_q + 1'b1;
                if (!full) fill_q <= fill_q + 1'b1;
            end
            accepted_q   <= i_data_valid;
            stageValid_q <= accepted_q && full;
            if (accepted_q && full) begin
                for (int a = 0; a < 3; a++) avgStage_q[a] <= shifted[a];
            end
            avgValid_q <= stageValid_q;
            if (stageValid_q) begin
                for (int a = 0; a < 3; a++) avg_q[a] <= avgStage_q[a];
            end
            filled_q <= full;
        end
    end

    assign o_avg_x     = avg_q[0];
    assign o_avg_y     = avg_q[1];
    assign o_avg_z     = avg_q[2];
    assign o_avg_valid = avgValid_q;
    assign o_filled    = filled_q;

endmodule

// File: doc/accel_avg_filter.md
# accel_avg_filter

Per-axis moving-average filter placed directly downstream of the ADXL345 accelerometer interface. It consumes the 10-bit two's-complement X/Y/Z samples and their data-valid pulse, keeps a circular history of the last 2^LOG2_DEPTH samples per axis, and emits the floor-averaged value of each axis with its own valid pulse. Its outputs drive the display and tilt logic, which then see a smoothed reading at the same rate as the sensor.

## Interface

Parameters:
- LOG2_DEPTH, default 3: window is 2^LOG2_DEPTH samples. Legal range is 1..5.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_clear  in  1  synchronous flush of the history, sums and fill state
- i_data_x  in  10  X sample, two's complement
- i_data_y  in  10  Y sample, two's complement
- i_data_z  in  10  Z sample, two's complement
- i_data_valid  in  1  one-cycle pulse; all three axes are valid together
- o_avg_x  out  10  averaged X, two's complement
- o_avg_y  out  10  averaged Y, two's complement
- o_avg_z  out  10  averaged Z, two's complement
- o_avg_valid  out  1  one-cycle pulse when the averages update
- o_filled  out  1  high once the window holds 2^LOG2_DEPTH samples since reset or clear

## Operation

- Storage per axis:
  - history array of 2^LOG2_DEPTH × 10 bits;
  - signed running sum of 10+LOG2_DEPTH bits;
  - one write pointer (LOG2_DEPTH bits) shared by all axes;
  - fill counter, saturating at 2^LOG2_DEPTH.
- Stage 1, the cycle i_data_valid is high:
  - oldest = history[wr_ptr], read combinationally;
  - sum <= sum + sext(new) − sext(oldest);
  - history[wr_ptr] <= new;
  - wr_ptr increments and wraps from 2^LOG2_DEPTH−1 to 0;
  - fill counter increments unless it is already saturated.
- Stage 2, one cycle after stage 1:
  - o_avg_* <= sum >>> LOG2_DEPTH. This is an arithmetic shift, so the result is floored toward −∞ and always fits in 10 bits.
  - o_avg_valid pulses only if the fill counter is saturated.
- Warm-up: history is zero-filled, and no o_avg_valid is produced until the window is full.
- i_clear:
  - next edge zeroes history, sums, wr_ptr, fill counter, o_avg_* and o_filled;
  - cancels any stage-2 pulse in flight.
- i_clear and i_data_valid in the same cycle: clear wins and the sample is dropped.
- Throughput: one sample per cycle. Back-to-back i_data_valid pulses are all accepted, with no stall and no drop.
- Arithmetic never overflows: the sum range is ±512·2^LOG2_DEPTH, which fits in 10+LOG2_DEPTH signed bits.

## Timing

- Reset values (asynchronous assert): every output is 0, and history, sums, wr_ptr and fill counter are all 0.
- Latency: a sample accepted at edge N produces o_avg_* and o_avg_valid at edge N+2.
- o_avg_valid is high for exactly one cycle per accepted sample once the window is full.
- o_avg_* hold their value between pulses.
- o_filled rises at edge N+1 after the 2^LOG2_DEPTH-th accepted sample. It stays high until reset or clear.
- Reset mid-operation (asynchronous assert): all state clears immediately. Any pulse in flight is lost.
- No handshake back to the producer. The block is always ready.

## Test plan

- Warm-up, LOG2_DEPTH=3: eight pulses of X=100, Y=−3, Z=0, spaced 10 cycles apart.
  - No o_avg_valid for the first seven samples.
  - After the 8th, exactly 2 cycles later: o_avg_valid=1 with X=100, Y=−3 (10'h3FD), Z=0; o_filled=1.
- Floor rounding: fill the window alternating −1, 0 on X (sum −4).
  - o_avg_x = −1 (10'h3FF), not 0.
- Wrap-around: X ramp 0..15, one sample per pulse.
  - After sample 15, o_avg_x = floor((8+…+15)/8) = 11.
  - The pulse count equals 9 (samples 7..15).
- Extremes: fill with X=−512, then with X=+511.
  - o_avg_x settles to −512 and then 511, with no overflow at any intermediate point.
- Back-to-back: i_data_valid held high for 12 consecutive cycles with constant 200.
  - Five consecutive o_avg_valid pulses at value 200, the first one 2 cycles after the 8th sample.
- Clear and reset:
  - i_clear coincident with a valid pulse drops that sample, drives o_filled and o_avg_* to 0, and requires 8 new samples before the next o_avg_valid.
  - Asserting i_rst_n low mid-stream zeroes all outputs asynchronously.
